// File: rtl/booth_job_sequencer.sv
// booth_job_sequencer
// Handshake front/back end around the sequential Booth multiplier. It takes
// an operand pair, pulses start, waits for done (ignoring the stale done left
// over from the previous job), captures the product and holds it on a
// valid/ready output. A saturating watchdog turns a hung multiplier into an
// error result.
module booth_job_sequencer #(
    parameter int W       = 8,
    parameter int TIMEOUT = 4*W+8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_multiplicand,
    input  logic [W-1:0]     in_multiplier,
    output logic             mul_start,
    output logic [W-1:0]     mul_m,
    output logic [W-1:0]     mul_q,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_product,
    output logic             out_error,
    output logic             busy
);

    localparam int unsigned WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT-1);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_GUARD  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [W-1:0]   mul_m_q, mul_m_d;
    logic [W-1:0]   mul_q_q, mul_q_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [2*W-1:0] out_product_q, out_product_d;
    logic           out_error_q, out_error_d;

    // Next-state, operand capture, watchdog and result capture.
    always_comb begin
        state_d       = state_q;
        mul_m_d       = mul_m_q;
        mul_q_d       = mul_q_q;
        wd_d          = wd_q;
        out_product_d = out_product_q;
        out_error_d   = out_error_q;
        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (in_valid) begin
                    mul_m_d = in_multiplicand;
                    mul_q_d = in_multiplier;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_GUARD;
            end
            // done is still high from the previous job here; skip one more cycle
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
                // done has priority over a simultaneous watchdog expiry
                if (mul_done) begin
                    out_product_d = mul_product;
                    out_error_d   = 1'b0;
                    state_d       = S_HOLD;
                end else if (wd_q == WD_LAST) begin
                    out_product_d = '0;
                    out_error_d   = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // State and data registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            mul_m_q       <= '0;
            mul_q_q       <= '0;
            wd_q          <= '0;
            out_product_q <= '0;
            out_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mul_m_q       <= mul_m_d;
            mul_q_q       <= mul_q_d;
            wd_q          <= wd_d;
            out_product_q <= out_product_d;
            out_error_q   <= out_error_d;
        end
    end

    // Control outputs decoded from state only, so reset acts on them at once.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        mul_start = (state_q == S_INIT) || (state_q == S_LAUNCH);
        out_valid = (state_q == S_HOLD);
    end

    assign mul_m       = mul_m_q;
    assign mul_q       = mul_q_q;
    assign out_product = out_product_q;
    assign out_error   = out_error_q;

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Directed bench for booth_job_sequencer with a behavioural Booth multiplier
// (auto mode) or hand-driven done/product (manual mode).
module tb_booth_job_sequencer;

    localparam int W       = 8;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_multiplicand;
    logic [W-1:0]     in_multiplier;
    logic             mul_start;
    logic [W-1:0]     mul_m;
    logic [W-1:0]     mul_q;
    logic             mul_done;
    logic [2*W-1:0]   mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_product;
    logic             out_error;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    logic           auto_mode;
    logic           man_done;
    logic [2*W-1:0] man_prod;
    logic           m_done;
    logic [2*W-1:0] m_prod;
    logic           m_run;
    int             m_cnt;

    booth_job_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplicand (in_multiplicand),
        .in_multiplier   (in_multiplier),
        .mul_start       (mul_start),
        .mul_m           (mul_m),
        .mul_q           (mul_q),
        .mul_done        (mul_done),
        .mul_product     (mul_product),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_product     (out_product),
        .out_error       (out_error),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Radix-2 Booth with a guard bit on the accumulator.
    function automatic logic [2*W-1:0] booth(input logic [W-1:0] m, input logic [W-1:0] q);
        logic signed [W:0] a;
        logic signed [W:0] ms;
        logic [W-1:0]      qq;
        logic              q1;
        a  = '0;
        ms = {m[W-1], m};
        qq = q;
        q1 = 1'b0;
        for (int i = 0; i < W; i++) begin
            case ({qq[0], q1})
                2'b01:   a = a + ms;
                2'b10:   a = a - ms;
                default: ;
            endcase
            q1 = qq[0];
            qq = {a[0], qq[W-1:1]};
            a  = a >>> 1;
        end
        return {a[W-1:0], qq};
    endfunction

    // Behavioural multiplier: restarts on start, reports done W+1 edges later.
    always @(posedge clk) begin
        if (mul_start) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_run  <= 1'b1;
        end else if (m_run) begin
            if (m_cnt == W-1) begin
                m_done <= 1'b1;
                m_prod <= booth(mul_m, mul_q);
                m_run  <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign mul_done    = auto_mode ? m_done : man_done;
    assign mul_product = auto_mode ? m_prod : man_prod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [W-1:0] m, input logic [W-1:0] q);
        in_multiplicand = m;
        in_multiplier   = q;
        in_valid        = 1'b1;
        step();
        in_valid        = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [2*W-1:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_multiplicand = '0; in_multiplier = '0;
        auto_mode = 1'b1; man_done = 1'b0; man_prod = '0;
        m_done = 1'b0; m_prod = '0; m_run = 1'b0; m_cnt = 0;

        // 1: reset and idle
        repeat (3) step();
        chk("rst_start",   32'(mul_start),   32'd1);
        chk("rst_valid",   32'(out_valid),   32'd0);
        chk("rst_ready",   32'(in_ready),    32'd0);
        chk("rst_busy",    32'(busy),        32'd1);
        chk("rst_product", 32'(out_product), 32'd0);
        chk("rst_error",   32'(out_error),   32'd0);
        chk("rst_m",       32'(mul_m),       32'd0);
        rst_n = 1'b1;
        #1;
        chk("init_start", 32'(mul_start), 32'd1);
        step();
        chk("idle_start", 32'(mul_start), 32'd0);
        chk("idle_ready", 32'(in_ready),  32'd1);
        chk("idle_busy",  32'(busy),      32'd0);

        // 2: 3 * -4
        submit(8'd3, 8'hFC);
        chk("launch_start", 32'(mul_start), 32'd1);
        chk("launch_m",     32'(mul_m),     32'd3);
        chk("launch_q",     32'(mul_q),     32'hFC);
        chk("launch_ready", 32'(in_ready),  32'd0);
        step();
        chk("guard_start", 32'(mul_start), 32'd0);
        wait_valid(100, n);
        chk("mul_latency",  32'(n + 1),      32'd10);
        chk("mul_product",  32'(out_product), 32'hFFF4);
        chk("mul_error",    32'(out_error),   32'd0);
        chk("mul_start_lo", 32'(mul_start),   32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("acc_valid", 32'(out_valid), 32'd0);
        chk("acc_ready", 32'(in_ready),  32'd1);

        // 3: stale done across LAUNCH/GUARD
        auto_mode = 1'b0; man_done = 1'b1; man_prod = 16'h1234;
        submit(8'd5, 8'd7);
        step();
        step();
        man_done = 1'b0;
        chk("stale_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stale_wait", 32'(out_valid), 32'd0);
        end
        man_prod = 16'hBEEF; man_done = 1'b1;
        step();
        chk("stale_cap_valid", 32'(out_valid),   32'd1);
        chk("stale_cap_prod",  32'(out_product), 32'hBEEF);
        chk("stale_cap_err",   32'(out_error),   32'd0);

        // 5: backpressure in HOLD, extra in_valid ignored
        man_prod = 16'h0F0F;
        in_multiplicand = 8'd9; in_multiplier = 8'd9; in_valid = 1'b1;
        held = out_product;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_valid", 32'(out_valid),   32'd1);
            chk("bp_prod",  32'(out_product), 32'(held));
            chk("bp_ready", 32'(in_ready),    32'd0);
            chk("bp_m",     32'(mul_m),       32'd5);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_acc_valid", 32'(out_valid), 32'd0);
        chk("bp_acc_ready", 32'(in_ready),  32'd1);
        chk("bp_acc_m",     32'(mul_m),     32'd5);

        // 4: watchdog expiry
        man_done = 1'b0; man_prod = 16'hABCD;
        submit(8'd1, 8'd1);
        step();
        step();
        wait_valid(200, n);
        chk("wd_latency", 32'(n),           32'(TIMEOUT));
        chk("wd_error",   32'(out_error),   32'd1);
        chk("wd_product", 32'(out_product), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 4b: done arrives in the expiry cycle -> done wins
        submit(8'd2, 8'd2);
        step();
        step();
        repeat (TIMEOUT-1) step();
        chk("tie_pre_valid", 32'(out_valid), 32'd0);
        man_done = 1'b1; man_prod = 16'h0055;
        step();
        chk("tie_valid",   32'(out_valid),   32'd1);
        chk("tie_error",   32'(out_error),   32'd0);
        chk("tie_product", 32'(out_product), 32'h0055);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 6: reset in WAIT, then -128 * -128
        auto_mode = 1'b1; man_done = 1'b0;
        submit(8'h80, 8'h80);
        repeat (5) step();
        chk("mid_pre_start", 32'(mul_start), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_start", 32'(mul_start), 32'd1);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_busy",  32'(busy),      32'd1);
        chk("mid_ready", 32'(in_ready),  32'd0);
        chk("mid_m",     32'(mul_m),     32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_idle_ready", 32'(in_ready), 32'd1);
        submit(8'h80, 8'h80);
        wait_valid(100, n);
        chk("neg_valid",   32'(out_valid),   32'd1);
        chk("neg_product", 32'(out_product), 32'h4000);
        chk("neg_error",   32'(out_error),   32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("neg_acc_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
